// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module  : simon_pkg
// Purpose : Shared widths, constants, FSM state type and rotate helpers for
//           the Simon128/128 iterative encryption sequencer.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package simon_pkg;

  localparam int WORD_W     = 64;
  localparam int BLOCK_W    = 128;
  localparam int ROUNDS_128 = 68;
  localparam int Z_LEN      = 62;

  // Simon z2 constant sequence. Read first-to-last it is
  //   1010111101110000001101001001100010100001000111111001011011 0011
  // It is stored so that bit 0 holds the first element. The register shifts
  // right once per round, so bit 0 always holds the element the next round
  // needs. This bit order matches the published Simon128/128 test vector.
  localparam logic [Z_LEN-1:0] Z2 = 62'h3369_F885_192C_0EF5;

  // Round-constant word c = 2^64 - 4. XOR-ing it with ka equals ~ka ^ 3.
  localparam logic [WORD_W-1:0] C_CONST = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 64-bit rotations by a constant amount (1..63).
  function automatic logic [WORD_W-1:0] rotl64(input logic [WORD_W-1:0] v,
                                               input int unsigned      n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] rotr64(input logic [WORD_W-1:0] v,
                                               input int unsigned      n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

endpackage : simon_pkg
`default_nettype wire

// File: rtl/simon_enc_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : simon_enc_seq_if
// Purpose : Job-in / ciphertext-out handshake bundle of the Simon sequencer.
// Signals : in_valid/in_ready/pt_i/k0_i  - job request (master drives valid)
//           out_valid/out_ready/ct_o     - ciphertext result (slave drives
//                                          valid)
// Modports: master - job producer / result consumer
//           slave  - the encryption engine
// Rev     : 1.0  initial release
// ============================================================================
interface simon_enc_seq_if;
  import simon_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] pt_i;
  logic [BLOCK_W-1:0] k0_i;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] ct_o;

  modport master (
    output in_valid, pt_i, k0_i, out_ready,
    input  in_ready, out_valid, ct_o
  );

  modport slave (
    input  in_valid, pt_i, k0_i, out_ready,
    output in_ready, out_valid, ct_o
  );

endinterface : simon_enc_seq_if
`default_nettype wire

// File: rtl/simon_round_step.sv
`default_nettype none
// ============================================================================
// Module  : simon_round_step
// Purpose : Purely combinational single Simon128/128 round together with one
//           step of the m=2 key schedule.
// Ports   : x, y      in  64  current state halves
//           ka, kb    in  64  current round key and next round key
//           z_bit     in  1   z-sequence element for this round
//           x_next    out 64  y ^ f(x) ^ ka
//           y_next    out 64  x
//           knew      out 64  key two rounds ahead
// Rev     : 1.0  initial release
// ============================================================================
module simon_round_step
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] ka,
  input  logic [WORD_W-1:0] kb,
  input  logic              z_bit,
  output logic [WORD_W-1:0] x_next,
  output logic [WORD_W-1:0] y_next,
  output logic [WORD_W-1:0] knew
);

  logic [WORD_W-1:0] w_f;
  logic [WORD_W-1:0] w_tmp3;
  logic [WORD_W-1:0] w_tmp;

  // Round function f(x) = (x<<<1 & x<<<8) ^ (x<<<2).
  assign w_f    = (rotl64(x, 1) & rotl64(x, 8)) ^ rotl64(x, 2);
  assign x_next = y ^ w_f ^ ka;
  assign y_next = x;

  // Key schedule: tmp = kb>>>3 ; tmp ^= tmp>>>1, which is (kb>>>3)^(kb>>>4).
  assign w_tmp3 = rotr64(kb, 3);
  assign w_tmp  = w_tmp3 ^ rotr64(w_tmp3, 1);
  // C_CONST ^ ka equals ~ka ^ 3.
  assign knew   = C_CONST ^ ka ^ w_tmp ^ {{(WORD_W-1){1'b0}}, z_bit};

endmodule : simon_round_step
`default_nettype wire

// File: rtl/simon_enc_seq.sv
`default_nettype none
// ============================================================================
// Module  : simon_enc_seq
// Purpose : Iterative Simon128/128 encryption engine. It takes one job, runs
//           ROUNDS rounds at one round per clock with on-the-fly key
//           expansion, and holds the ciphertext until the consumer takes it.
// Ports   : clk      in   1   system clock
//           rst_n    in   1   asynchronous active-low reset
//           bus      slave    job in / ciphertext out handshake
//           busy_o   out  1   high while rounds are running
//           round_o  out  7   current round index
// Rev     : 1.0  initial release
// ============================================================================
module simon_enc_seq
  import simon_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_128     // legal 1..68
)
(
  input  logic             clk,
  input  logic             rst_n,
  simon_enc_seq_if.slave   bus,
  output logic             busy_o,
  output logic [6:0]       round_o
);

  localparam logic [6:0] C_LAST_RND = 7'(ROUNDS - 1);

  state_t             r_state;
  state_t             w_state_next;

  logic [WORD_W-1:0]  r_x;
  logic [WORD_W-1:0]  r_y;
  logic [WORD_W-1:0]  r_ka;
  logic [WORD_W-1:0]  r_kb;
  logic [Z_LEN-1:0]   r_z;
  logic [6:0]         r_rnd;
  logic [BLOCK_W-1:0] r_ct;

  logic [WORD_W-1:0]  w_x_next;
  logic [WORD_W-1:0]  w_y_next;
  logic [WORD_W-1:0]  w_knew;
  logic               w_last;

  // --------------------------------------------------------------------------
  // Round datapath
  // --------------------------------------------------------------------------
  simon_round_step u_step (
    .x      (r_x),
    .y      (r_y),
    .ka     (r_ka),
    .kb     (r_kb),
    .z_bit  (r_z[0]),
    .x_next (w_x_next),
    .y_next (w_y_next),
    .knew   (w_knew)
  );

  assign w_last = (r_rnd == C_LAST_RND);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_next = RUN;
      RUN:     if (w_last)        w_state_next = DONE;
      DONE:    if (bus.out_ready) w_state_next = IDLE;
      default:                    w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: job load, round iteration, result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_ka  <= '0;
      r_kb  <= '0;
      r_z   <= Z2;
      r_rnd <= '0;
      r_ct  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // The inputs are sampled only at the accept edge.
          if (bus.in_valid) begin
            r_x   <= bus.pt_i[BLOCK_W-1:WORD_W];
            r_y   <= bus.pt_i[WORD_W-1:0];
            r_ka  <= bus.k0_i[WORD_W-1:0];
            r_kb  <= bus.k0_i[BLOCK_W-1:WORD_W];
            r_z   <= Z2;
            r_rnd <= '0;
          end
        end
        RUN: begin
          r_x  <= w_x_next;
          r_y  <= w_y_next;
          r_ka <= r_kb;
          r_kb <= w_knew;
          // Rotating the z register wraps it every 62 rounds. Rounds 62..67
          // therefore reuse elements 0..5.
          r_z  <= {r_z[0], r_z[Z_LEN-1:1]};
          if (w_last) begin
            // round_o holds the last index while the result waits in DONE.
            r_ct <= {w_x_next, w_y_next};
          end else begin
            r_rnd <= r_rnd + 7'd1;
          end
        end
        DONE: begin
          // ct_o keeps its value after hand-off. Only the index clears.
          if (bus.out_ready) r_rnd <= '0;
        end
        default: begin
          r_rnd <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.ct_o      = r_ct;
  assign busy_o        = (r_state == RUN);
  assign round_o       = r_rnd;

endmodule : simon_enc_seq
`default_nettype wire
